iob_clock_reset_sequencer: RTL and testbench

- Controls the clock wizard (MMCM/PLL) and sequences reset release for the domains it feeds.
- Holds the wizard in reset, then waits for its lock with a timeout and bounded retries.
- Requires lock to stay stable for a settle window, then releases the downstream domain resets one stage at a time.
- Runs from the free-running board reference clock, upstream of the wizard, and drives the wizard's reset input.

---
 rtl/iob_clock_reset_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_iob_clock_reset_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/iob_clock_reset_sequencer.sv
// Clock-wizard reset controller: lock wait with timeout/retry, settle window, staged domain reset release.
// Optional status ports (state_o, attempts_o) are enabled by IOB_CLOCK_RESET_SEQUENCER_STATUS_EN.
module iob_clock_reset_sequencer #(
    parameter int N_DOMAINS     = 2,
    parameter int CNT_W         = 16,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1000,
    parameter int SETTLE_CYCLES = 64,
    parameter int STAGE_DLY     = 8,
    parameter int MAX_RETRY     = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 locked_i,
    input  logic                 restart_i,
    output logic                 wiz_rst_o,
    output logic [N_DOMAINS-1:0] dom_rst_o,
    output logic                 ready_o,
    output logic                 fault_o,
`ifdef IOB_CLOCK_RESET_SEQUENCER_STATUS_EN
    output logic [2:0]           state_o,
    output logic [7:0]           attempts_o,
`endif
    output logic                 lock_lost_o
);

    // state | meaning
    // WIZ_RST   | wizard held in reset for RST_CYCLES
    // WAIT_LOCK | waiting for lock, bounded by LOCK_TIMEOUT
    // SETTLE    | lock must stay high SETTLE_CYCLES in a row
    // RELEASE   | domain resets cleared one per STAGE_DLY
    // RUN       | all domains out of reset
    // FAULT     | retries exhausted; needs restart_i or rst_i
    typedef enum logic [2:0] {
        S_WIZ_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_SETTLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    localparam int SW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 64'd1;
    localparam bit CFG_OK = (longint'(RST_CYCLES) <= CNT_MAX) && (longint'(LOCK_TIMEOUT) <= CNT_MAX) &&
                            (longint'(SETTLE_CYCLES) <= CNT_MAX) && (longint'(STAGE_DLY) <= CNT_MAX);

    localparam logic [CNT_W-1:0]     RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]     TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     STAGE_LAST  = CNT_W'(STAGE_DLY - 1);
    localparam logic [SW-1:0]        LAST_STAGE  = SW'(N_DOMAINS - 1);
    localparam logic [3:0]           RETRY_MAX   = 4'(MAX_RETRY);
    localparam logic [N_DOMAINS-1:0] DOM_ONE     = N_DOMAINS'(1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             retry_q, retry_d;
    logic [SW-1:0]          stage_q, stage_d;
    logic                   sync1_q, lk_s_q;
    logic                   wiz_rst_q, wiz_rst_d;
    logic [N_DOMAINS-1:0]   dom_rst_q, dom_rst_d;
    logic                   ready_q, ready_d;
    logic                   fault_q, fault_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   wiz_entry;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        retry_d     = retry_q;
        stage_d     = stage_q;
        dom_rst_d   = dom_rst_q;
        lock_lost_d = lock_lost_q;
        wiz_entry   = 1'b0;

        if (restart_i) begin
            state_d   = S_WIZ_RST;
            cnt_d     = '0;
            retry_d   = '0;
            dom_rst_d = '1;
            wiz_entry = 1'b1;
        end else begin
            case (state_q)
                S_WIZ_RST: begin
                    dom_rst_d = '1;
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lk_s_q) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        cnt_d = '0;
                        if (retry_q == RETRY_MAX) begin
                            state_d = S_FAULT;
                        end else begin
                            retry_d   = retry_q + 1'b1;
                            state_d   = S_WIZ_RST;
                            wiz_entry = 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (!lk_s_q) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_d   = S_RELEASE;
                        cnt_d     = '0;
                        stage_d   = '0;
                        dom_rst_d = ~DOM_ONE;
                    end
                end
                S_RELEASE: begin
                    if (!lk_s_q) begin
                        state_d     = S_WIZ_RST;
                        cnt_d       = '0;
                        dom_rst_d   = '1;
                        lock_lost_d = 1'b1;
                        wiz_entry   = 1'b1;
                    end else if (stage_q == LAST_STAGE) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else if (cnt_q == STAGE_LAST) begin
                        cnt_d     = '0;
                        stage_d   = stage_q + 1'b1;
                        dom_rst_d = dom_rst_q & ~(DOM_ONE << (int'(stage_q) + 1));
                    end
                end
                S_RUN: begin
                    cnt_d = cnt_q;
                    if (!lk_s_q) begin
                        state_d     = S_WIZ_RST;
                        cnt_d       = '0;
                        dom_rst_d   = '1;
                        lock_lost_d = 1'b1;
                        wiz_entry   = 1'b1;
                    end
                end
                default: begin
                    // FAULT and any illegal encoding park with everything held in reset
                    state_d   = S_FAULT;
                    cnt_d     = cnt_q;
                    dom_rst_d = '1;
                end
            endcase
        end

        wiz_rst_d = (state_d == S_WIZ_RST) || (state_d == S_FAULT);
        ready_d   = (state_d == S_RUN);
        fault_d   = (state_d == S_FAULT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_WIZ_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            stage_q     <= '0;
            sync1_q     <= 1'b0;
            lk_s_q      <= 1'b0;
            wiz_rst_q   <= 1'b1;
            dom_rst_q   <= '1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            stage_q     <= stage_d;
            sync1_q     <= locked_i;
            lk_s_q      <= sync1_q;
            wiz_rst_q   <= wiz_rst_d;
            dom_rst_q   <= dom_rst_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            assert (CFG_OK) else $error("iob_clock_reset_sequencer: timing parameter exceeds CNT_W range");
        end
    end

    assign wiz_rst_o   = wiz_rst_q;
    assign dom_rst_o   = dom_rst_q;
    assign ready_o     = ready_q;
    assign fault_o     = fault_q;
    assign lock_lost_o = lock_lost_q;

`ifdef IOB_CLOCK_RESET_SEQUENCER_STATUS_EN
    logic [7:0] attempts_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            attempts_q <= '0;
        end else if (wiz_entry && (attempts_q != 8'hFF)) begin
            attempts_q <= attempts_q + 1'b1;
        end
    end

    assign state_o    = state_q;
    assign attempts_o = attempts_q;
`endif

endmodule

// File: tb/tb_iob_clock_reset_sequencer.sv
// Directed self-checking bench for iob_clock_reset_sequencer with default parameters.
module tb_iob_clock_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       locked_i = 1'b0;
    logic       restart_i = 1'b0;
    logic       wiz_rst_o;
    logic [1:0] dom_rst_o;
    logic       ready_o;
    logic       fault_o;
    logic       lock_lost_o;
`ifdef IOB_CLOCK_RESET_SEQUENCER_STATUS_EN
    logic [2:0] state_o;
    logic [7:0] attempts_o;
`endif

    int checks   = 0;
    int failures = 0;
    int n;

    iob_clock_reset_sequencer dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .locked_i    (locked_i),
        .restart_i   (restart_i),
        .wiz_rst_o   (wiz_rst_o),
        .dom_rst_o   (dom_rst_o),
        .ready_o     (ready_o),
        .fault_o     (fault_o),
`ifdef IOB_CLOCK_RESET_SEQUENCER_STATUS_EN
        .state_o     (state_o),
        .attempts_o  (attempts_o),
`endif
        .lock_lost_o (lock_lost_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ticks while wiz_rst_o stays at lvl; returns cycles elapsed (bounded).
    task automatic run_while_wiz(input logic lvl, input int lim, output int cnt);
        cnt = 0;
        while (wiz_rst_o === lvl && cnt < lim) begin
            tick();
            cnt++;
        end
    endtask

    task automatic wait_dom0_low(input int lim, output int cnt);
        cnt = 0;
        while (dom_rst_o[0] !== 1'b0 && cnt < lim) begin
            tick();
            cnt++;
        end
    endtask

    task automatic wait_ready(input int lim, output int cnt);
        cnt = 0;
        while (ready_o !== 1'b1 && cnt < lim) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        // ---------------- reset values ----------------
        ticks(3);
        chk("rst_wiz", wiz_rst_o, 1);
        chk("rst_dom", dom_rst_o, 3);
        chk("rst_ready", ready_o, 0);
        chk("rst_fault", fault_o, 0);
        chk("rst_lock_lost", lock_lost_o, 0);
`ifdef IOB_CLOCK_RESET_SEQUENCER_STATUS_EN
        chk("rst_state", state_o, 0);
        chk("rst_attempts", attempts_o, 0);
`endif

        // ---------------- nominal lock ----------------
        rst_i = 1'b0;
        run_while_wiz(1'b1, 100, n);
        chk("nom_wiz_pulse", n, 16);
        ticks(10);
        locked_i = 1'b1;
        // sampled at next edge, 2 sync stages, one WAIT_LOCK cycle, 64 settle cycles
        wait_dom0_low(200, n);
        chk("nom_dom0_delay", n, 67);
        chk("nom_dom_after0", dom_rst_o, 2);
        n = 0;
        while (dom_rst_o[1] !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        chk("nom_dom1_delay", n, 8);
        chk("nom_ready_not_yet", ready_o, 0);
        tick();
        chk("nom_ready", ready_o, 1);
        chk("nom_dom_run", dom_rst_o, 0);
        chk("nom_wiz_run", wiz_rst_o, 0);
`ifdef IOB_CLOCK_RESET_SEQUENCER_STATUS_EN
        chk("nom_state_run", state_o, 4);
        chk("nom_attempts", attempts_o, 0);
`endif

        // ---------------- lock loss in RUN ----------------
        locked_i = 1'b0;
        ticks(2);
        chk("loss_dom_still_run", dom_rst_o, 0);
        tick();
        chk("loss_dom", dom_rst_o, 3);
        chk("loss_ready", ready_o, 0);
        chk("loss_lock_lost", lock_lost_o, 1);
        chk("loss_wiz", wiz_rst_o, 1);
`ifdef IOB_CLOCK_RESET_SEQUENCER_STATUS_EN
        chk("loss_attempts", attempts_o, 1);
`endif
        locked_i = 1'b1;
        wait_ready(300, n);
        chk("loss_rerun_ready", ready_o, 1);
        chk("loss_sticky", lock_lost_o, 1);

        // ---------------- restart then settle glitch ----------------
        locked_i  = 1'b0;
        restart_i = 1'b1;
        tick();
        restart_i = 1'b0;
        chk("rs_wiz", wiz_rst_o, 1);
        chk("rs_dom", dom_rst_o, 3);
        chk("rs_keep_lock_lost", lock_lost_o, 1);
        run_while_wiz(1'b1, 100, n);
        chk("rs_wiz_pulse", n, 16);
        locked_i = 1'b1;
        // SETTLE entered 2 edges after the first sample; drop input partway through settle
        ticks(42);
        chk("gl_dom_before", dom_rst_o, 3);
        locked_i = 1'b0;
        ticks(3);
        locked_i = 1'b1;
        wait_dom0_low(200, n);
        chk("gl_full_resettle", n, 67);
        chk("gl_fault", fault_o, 0);
`ifdef IOB_CLOCK_RESET_SEQUENCER_STATUS_EN
        chk("gl_attempts", attempts_o, 2);
`endif

        // ---------------- priority mid-RELEASE ----------------
        ticks(3);
        chk("pr_in_release", dom_rst_o, 2);
        rst_i     = 1'b1;
        restart_i = 1'b1;
        tick();
        rst_i     = 1'b0;
        restart_i = 1'b0;
        chk("pr_wiz", wiz_rst_o, 1);
        chk("pr_dom", dom_rst_o, 3);
        chk("pr_ready", ready_o, 0);
        chk("pr_lock_lost", lock_lost_o, 0);
`ifdef IOB_CLOCK_RESET_SEQUENCER_STATUS_EN
        chk("pr_attempts_rst", attempts_o, 0);
        ticks(2);
        restart_i = 1'b1;
        tick();
        restart_i = 1'b0;
        chk("pr_attempts_restart", attempts_o, 1);
`endif

        // ---------------- timeout / retry to FAULT ----------------
        locked_i = 1'b0;
        rst_i    = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            run_while_wiz(1'b1, 100, n);
            chk($sformatf("to_pulse%0d", k), n, 16);
            chk($sformatf("to_dom%0d", k), dom_rst_o, 3);
            run_while_wiz(1'b0, 1200, n);
            chk($sformatf("to_wait%0d", k), n, 1000);
        end
        chk("to_fault", fault_o, 1);
        chk("to_fault_wiz", wiz_rst_o, 1);
        chk("to_fault_dom", dom_rst_o, 3);
        ticks(20);
        chk("to_fault_hold", fault_o, 1);
`ifdef IOB_CLOCK_RESET_SEQUENCER_STATUS_EN
        chk("to_state_fault", state_o, 5);
        chk("to_attempts", attempts_o, 3);
`endif
        restart_i = 1'b1;
        tick();
        restart_i = 1'b0;
        chk("to_restart_fault", fault_o, 0);
        chk("to_restart_wiz", wiz_rst_o, 1);
        run_while_wiz(1'b1, 100, n);
        chk("to_restart_pulse", n, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
